// File: rtl/endstop_conditioner_if.sv
// Endstop bus between the conditioner (slave) and its consumers (master).
// The latch_clr/latched pair exists only when ENDSTOP_LATCH_EN is defined.
interface endstop_conditioner_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] pins_in;
    logic [WIDTH-1:0] endstops;
    logic [WIDTH-1:0] hit_pulse;
    logic             hit_any;
`ifdef ENDSTOP_LATCH_EN
    logic [WIDTH-1:0] latch_clr;
    logic [WIDTH-1:0] latched;
`endif

    modport slave (
        input  pins_in,
`ifdef ENDSTOP_LATCH_EN
        input  latch_clr,
        output latched,
`endif
        output endstops,
        output hit_pulse,
        output hit_any
    );

    modport master (
        output pins_in,
`ifdef ENDSTOP_LATCH_EN
        output latch_clr,
        input  latched,
`endif
        input  endstops,
        input  hit_pulse,
        input  hit_any
    );
endinterface

// File: rtl/endstop_conditioner.sv
// Endstop front end: 2-flop sync, polarity fix, tick-based debounce, hit pulses.
// Define ENDSTOP_LATCH_EN to add the sticky per-channel trip latch.
module endstop_conditioner #(
    parameter int               WIDTH           = 6,
    parameter int               TICK_DIV        = 500,
    parameter int               DEBOUNCE_TICKS  = 4,
    parameter logic [WIDTH-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    endstop_conditioner_if.slave   bus
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_TICKS) + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 1);

    logic [WIDTH-1:0]  sync1, sync2;
    logic [WIDTH-1:0]  norm;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [DEB_W-1:0]  deb_cnt [WIDTH];
    logic [WIDTH-1:0]  endstops, endstops_q;
    logic [WIDTH-1:0]  hit_pulse;
    logic              hit_any;

    // Sync flops idle at the inactive pin level so reset release never looks like a trip.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= ACTIVE_LOW_MASK;
            sync2 <= ACTIVE_LOW_MASK;
        end else begin
            // NOTE: non-blocking so sync2 takes the old sync1; blocking would collapse the two stages.
            sync1 <= bus.pins_in;
            sync2 <= sync1;
        end
    end

    assign norm = sync2 ^ ACTIVE_LOW_MASK;
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // One agreeing tick clears the count, so only DEBOUNCE_TICKS consecutive disagreements toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            endstops <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is safe to reset.
            for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (norm[i] == endstops[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    endstops[i] <= ~endstops[i];
                    deb_cnt[i]  <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Pulse and any-hit both trail endstops by one clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            endstops_q <= '0;
            hit_pulse  <= '0;
            hit_any    <= 1'b0;
        end else begin
            endstops_q <= endstops;
            hit_pulse  <= endstops & ~endstops_q;
            hit_any    <= |endstops;
        end
    end

    assign bus.endstops  = endstops;
    assign bus.hit_pulse = hit_pulse;
    assign bus.hit_any   = hit_any;

`ifdef ENDSTOP_LATCH_EN
    logic [WIDTH-1:0] latched;

    // Set has priority over clear so a trip in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latched <= '0;
        end else begin
            latched <= (latched & ~bus.latch_clr) | hit_pulse;
        end
    end

    assign bus.latched = latched;
`endif

endmodule

// File: tb/tb_endstop_conditioner.sv
// Directed bench for endstop_conditioner (TICK_DIV=4, DEBOUNCE_TICKS=3, mask 6'b000010).
// Cycle n is sampled 1 time unit after the n-th posedge following reset release.
module tb_endstop_conditioner;
    localparam int          WIDTH = 6;
    localparam logic [5:0]  MASK  = 6'b000010;
    localparam int          HIST  = 128;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   tests   = 0;
    int   fails   = 0;

    logic [5:0] es_h  [HIST];
    logic [5:0] hp_h  [HIST];
    logic       ha_h  [HIST];
    logic [5:0] lat_h [HIST];

    endstop_conditioner_if #(.WIDTH(WIDTH)) bus ();

    endstop_conditioner #(
        .WIDTH(WIDTH), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .ACTIVE_LOW_MASK(MASK)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset(input logic [5:0] p);
        bus.pins_in = p;
`ifdef ENDSTOP_LATCH_EN
        bus.latch_clr = '0;
`endif
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic sample(input int n);
        es_h[n] = bus.endstops;
        hp_h[n] = bus.hit_pulse;
        ha_h[n] = bus.hit_any;
`ifdef ENDSTOP_LATCH_EN
        lat_h[n] = bus.latched;
`else
        lat_h[n] = '0;
`endif
    endtask

    function automatic int first_high(input int b, input int last);
        for (int n = 1; n <= last; n++) if (es_h[n][b]) return n;
        return -1;
    endfunction

    function automatic int pulse_count(input int b, input int last);
        int c = 0;
        for (int n = 1; n <= last; n++) if (hp_h[n][b]) c++;
        return c;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0] acc_es, acc_hp;
        logic       acc_ha;

        // Reset release with every pin at its inactive level.
        apply_reset(6'b000010);
        check("rst_endstops", bus.endstops, 0);
        check("rst_hit_pulse", bus.hit_pulse, 0);
        check("rst_hit_any", bus.hit_any, 0);
`ifdef ENDSTOP_LATCH_EN
        check("rst_latched", bus.latched, 0);
`endif
        acc_es = '0; acc_hp = '0; acc_ha = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            acc_es |= bus.endstops;
            acc_hp |= bus.hit_pulse;
            acc_ha |= bus.hit_any;
        end
        check("idle_endstops", acc_es, 0);
        check("idle_hit_pulse", acc_hp, 0);
        check("idle_hit_any", acc_ha, 0);

        // pin0 high from cycle 0: disagreeing ticks at edges 4, 8, 12 -> toggle on edge 12.
        apply_reset(6'b000011);
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1; sample(n);
        end
        check("p0_rise_cycle", first_high(0, 24), 12);
        check("p0_within_bound", (first_high(0, 24) > 0 && first_high(0, 24) <= 15), 1);
        check("p0_pulse_c12", hp_h[12], 6'b000000);
        check("p0_pulse_c13", hp_h[13], 6'b000001);
        check("p0_pulse_count", pulse_count(0, 24), 1);
        check("p0_any_c12", ha_h[12], 0);
        check("p0_any_c13", ha_h[13], 1);

        // pin2 glitch lasting only two ticks must be rejected.
        apply_reset(6'b000010);
        bus.pins_in = 6'b000110;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1; sample(n);
            if (n == 8) bus.pins_in = 6'b000010;
        end
        check("glitch_no_rise", first_high(2, 40), -1);
        check("glitch_no_pulse", pulse_count(2, 40), 0);
        check("glitch_endstops_end", es_h[40], 0);

        // Active-low pin1: asserted by 0, released by 1 at cycle 20 -> clears on edge 32.
        apply_reset(6'b000000);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1; sample(n);
            if (n == 20) bus.pins_in = 6'b000010;
        end
        check("al_c11", es_h[11], 6'b000000);
        check("al_c12", es_h[12], 6'b000010);
        check("al_pulse_c13", hp_h[13], 6'b000010);
        check("al_hold_c31", es_h[31], 6'b000010);
        check("al_release_c32", es_h[32], 6'b000000);
        check("al_any_c33", ha_h[33], 0);
        check("al_pulse_count", pulse_count(1, 40), 1);

        // pins 3 and 5 rise together.
        apply_reset(6'b000010);
        bus.pins_in = 6'b101010;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1; sample(n);
        end
        check("pair_c11", es_h[11], 6'b000000);
        check("pair_c12", es_h[12], 6'b101000);
        check("pair_pulse_c13", hp_h[13], 6'b101000);
        check("pair_pulse_c14", hp_h[14], 6'b000000);

        // Reset mid-count: pin0 released at cycle 12, tick at edge 16 counts 1, reset at cycle 18.
        apply_reset(6'b000011);
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk); #1; sample(n);
            if (n == 12) bus.pins_in = 6'b000010;
        end
        check("mid_pre_endstops", es_h[18], 6'b000001);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_endstops", bus.endstops, 0);
        check("mid_rst_hit_any", bus.hit_any, 0);
        check("mid_rst_hit_pulse", bus.hit_pulse, 0);
        bus.pins_in = 6'b000011;
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1; sample(n);
        end
        check("mid_restart_rise", first_high(0, 16), 12);

`ifdef ENDSTOP_LATCH_EN
        // pin4 trips; latch_clr held over edges 14 (with set) and 15 (alone).
        apply_reset(6'b000010);
        bus.pins_in = 6'b010010;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1; sample(n);
            if (n == 13) bus.latch_clr = 6'b010000;
            if (n == 15) bus.latch_clr = 6'b000000;
        end
        check("lat_pulse_c13", hp_h[13], 6'b010000);
        check("lat_c13", lat_h[13], 6'b000000);
        check("lat_set_wins_c14", lat_h[14], 6'b010000);
        check("lat_clr_c15", lat_h[15], 6'b000000);
        check("lat_c20", lat_h[20], 6'b000000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
